paddle_pot_emu: RTL

//  N-channel paddle potentiometer emulator for the AY-3-8500 core.

---
 rtl/paddle_pot_emu_pkg.sv | 20 ++
 rtl/paddle_pot_emu_channel.sv | 121 ++++++++++++
 rtl/paddle_pot_emu.sv | 74 +++++++
 3 files changed

// File: rtl/paddle_pot_emu_pkg.sv
// Shared types and helpers for the paddle potentiometer emulator.
// Optional build macro used by the emulator files: PADDLE_ACCEL_EN.
package paddle_pkg;

    typedef enum logic [1:0] {
        PM_DIGITAL = 2'd0,
        PM_Y       = 2'd1,
        PM_X       = 2'd2,
        PM_PADDLE  = 2'd3
    } pmode_t;

    localparam int POS_MIN = 0;
    localparam int POS_MAX = 255;

    // Signed two's-complement stick value to unsigned 0..255 (-128 -> 0x00, +127 -> 0xFF)
    function automatic logic [7:0] stick_to_u8(input logic [7:0] s);
        return {~s[7], s[6:0]};
    endfunction

endpackage

// File: rtl/paddle_pot_emu_channel.sv
// One emulated paddle channel: digital position, RC-charge down-counter
// and (with PADDLE_ACCEL_EN defined) a held-frame acceleration counter.
module paddle_channel
    import paddle_pkg::*;
#(
    parameter int POS_CENTER = 128,
    parameter int SPD_SLOW   = 5,
    parameter int SPD_FAST   = 8,
    parameter int SPD_MAX    = 12,
    parameter int ACCEL_FR   = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       fr,
    input  logic       ln,
    input  logic       speed_fast,
    input  logic [1:0] mode,
    input  logic       invert,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] ana_x,
    input  logic [7:0] ana_y,
    input  logic [7:0] paddle,
    output logic       pot_out,
    output logic [7:0] pos_out
);

    logic [7:0] pos;
    logic [7:0] cap;
    logic [7:0] load_val;
    logic [7:0] pos_next;
    logic [8:0] pos_sum;
    logic [8:0] base_step;
    logic [8:0] step;
    pmode_t     pmode;

    assign pmode     = pmode_t'(mode);
    assign base_step = speed_fast ? 9'(SPD_FAST) : 9'(SPD_SLOW);

`ifdef PADDLE_ACCEL_EN
    logic [7:0] hold;
    logic [7:0] hold_eff;
    logic       last_dir;
    logic       held;
    logic [8:0] accel_sum;

    // Step grows by one every ACCEL_FR held frames; a direction change restarts the count
    always_comb begin
        held      = btn_up ^ btn_down;
        hold_eff  = (btn_down != last_dir) ? 8'd0 : hold;
        accel_sum = base_step + 9'(hold_eff / 8'(ACCEL_FR));
        step      = base_step;
        if (held) begin
            step = (accel_sum > 9'(SPD_MAX)) ? 9'(SPD_MAX) : accel_sum;
        end
    end

    // Held-frame counter advances once per frame and freezes once the step ceiling is reached
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            hold     <= 8'd0;
            last_dir <= 1'b0;
        end else if (fr) begin
            if (pmode == PM_DIGITAL && held) begin
                hold     <= (step == 9'(SPD_MAX)) ? hold_eff : hold_eff + 8'd1;
                last_dir <= btn_down;
            end else begin
                hold <= 8'd0;
            end
        end
    end
`else
    assign step = base_step;

    // Acceleration settings only matter in the accelerated build; this keeps them referenced here
    if (SPD_MAX < 1 || ACCEL_FR < 1) begin : g_accel_cfg_unused
    end
`endif

    // Saturating 9-bit position update; down wins when both buttons are held
    always_comb begin
        pos_next = pos;
        pos_sum  = 9'd0;
        if (btn_down) begin
            pos_sum  = {1'b0, pos} + step;
            pos_next = (pos_sum > 9'(POS_MAX)) ? 8'(POS_MAX) : pos_sum[7:0];
        end else if (btn_up) begin
            pos_next = ({1'b0, pos} < step) ? 8'(POS_MIN) : 8'({1'b0, pos} - step);
        end
    end

    // Select the frame's charge value from the chosen source, then optionally invert it
    always_comb begin
        case (pmode)
            PM_DIGITAL: load_val = pos;
            PM_Y:       load_val = stick_to_u8(ana_y);
            PM_X:       load_val = stick_to_u8(ana_x);
            default:    load_val = paddle;
        endcase
        load_val = load_val ^ {8{invert}};
    end

    // Load on frame start (position uses its pre-update value), otherwise count down per line
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            pos <= 8'(POS_CENTER);
            cap <= 8'd0;
        end else if (fr) begin
            cap <= load_val;
            if (pmode == PM_DIGITAL) begin
                pos <= pos_next;
            end
        end else if (ln && cap != 8'd0) begin
            cap <= cap - 8'd1;
        end
    end

    assign pot_out = (cap == 8'd0);
    assign pos_out = pos;

endmodule

// File: rtl/paddle_pot_emu.sv
// N-channel paddle potentiometer emulator for the AY-3-8500 core.
// Shared hsync/vsync edge detection plus one paddle_channel per channel.
// Optional build macro: PADDLE_ACCEL_EN (held-button step acceleration).
module paddle_pot_emu
    import paddle_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int POS_CENTER = 128,
    parameter int SPD_SLOW   = 5,
    parameter int SPD_FAST   = 8,
    parameter int SPD_MAX    = 12,
    parameter int ACCEL_FR   = 8
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  hs,
    input  logic                  vs,
    input  logic                  speed_fast,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     invert,
    input  logic [NUM_CH-1:0]     btn_up,
    input  logic [NUM_CH-1:0]     btn_down,
    input  logic [8*NUM_CH-1:0]   ana_x,
    input  logic [8*NUM_CH-1:0]   ana_y,
    input  logic [8*NUM_CH-1:0]   paddle,
    output logic [NUM_CH-1:0]     pot_out,
    output logic [8*NUM_CH-1:0]   pos_out
);

    logic hs_q;
    logic vs_q;
    logic fr;
    logic ln;

    // Delayed sync copies for rising-edge detection
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            hs_q <= hs;
            vs_q <= vs;
        end
    end

    assign fr = vs & ~vs_q;
    assign ln = hs & ~hs_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        paddle_channel #(
            .POS_CENTER (POS_CENTER),
            .SPD_SLOW   (SPD_SLOW),
            .SPD_FAST   (SPD_FAST),
            .SPD_MAX    (SPD_MAX),
            .ACCEL_FR   (ACCEL_FR)
        ) u_ch (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .fr         (fr),
            .ln         (ln),
            .speed_fast (speed_fast),
            .mode       (mode[2*i +: 2]),
            .invert     (invert[i]),
            .btn_up     (btn_up[i]),
            .btn_down   (btn_down[i]),
            .ana_x      (ana_x[8*i +: 8]),
            .ana_y      (ana_y[8*i +: 8]),
            .paddle     (paddle[8*i +: 8]),
            .pot_out    (pot_out[i]),
            .pos_out    (pos_out[8*i +: 8])
        );
    end

endmodule
